// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scanner: active-low gfedcba glyphs,
// the blank pattern and the legal digit-count range.
package seg_pkg;

  localparam int MIN_DIGITS      = 1;
  localparam int MAX_DIGITS      = 8;
  localparam int MIN_REFRESH_DIV = 2;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Index is the nibble value; bit 6 is segment g, bit 0 is segment a.
  localparam logic [6:0] SEG_HEX [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

  function automatic logic [6:0] hex_segments(input logic [3:0] nibble);
    return SEG_HEX[nibble];
  endfunction

endpackage

// File: rtl/hex_to_segments.sv
// Combinational hex nibble to active-low gfedcba segment decoder.
module hex_to_segments
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = hex_segments(nibble);
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed hex display driver: prescaled digit scan, tear-free frame
// update, leading-zero blanking and registered active-low outputs.
module seven_seg_scanner
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    lz_blank,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_done
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  if (NUM_DIGITS < MIN_DIGITS || NUM_DIGITS > MAX_DIGITS ||
      REFRESH_DIV < MIN_REFRESH_DIV) begin : g_bad_cfg
    $error("seven_seg_scanner: NUM_DIGITS or REFRESH_DIV out of range");
  end

  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] pend_val;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic [4*NUM_DIGITS-1:0] disp_val;
  logic [NUM_DIGITS-1:0]   disp_dp;
  logic                    frame_wrap_q;

  logic                    pre_wrap;
  logic                    frame_wrap;
  logic                    zero_run;
  logic [NUM_DIGITS-1:0]   lead_zero;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_blank;
  logic [NUM_DIGITS-1:0]   cur_sel;
  logic [6:0]              dec_seg;

  always_comb begin
    pre_wrap   = enable && (cnt == CNT_LAST);
    frame_wrap = pre_wrap && (idx == IDX_LAST);
  end

  // A digit is a leading zero when it and every digit above it are zero;
  // digit 0 is excluded so a zero value still shows one glyph.
  always_comb begin
    zero_run  = 1'b1;
    lead_zero = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run     = zero_run && (disp_val[4*i +: 4] == 4'h0);
      lead_zero[i] = zero_run;
    end
  end

  always_comb begin
    cur_nib   = disp_val[3:0];
    cur_dp    = disp_dp[0];
    cur_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib   = disp_val[4*i +: 4];
        cur_dp    = disp_dp[i];
        cur_blank = lz_blank && lead_zero[i];
      end
    end
    cur_sel = ~(NUM_DIGITS'(1) << idx);
  end

  hex_to_segments u_hex_to_segments (
    .nibble (cur_nib),
    .seg    (dec_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      idx          <= '0;
      pend_val     <= '0;
      pend_dp      <= '0;
      disp_val     <= '0;
      disp_dp      <= '0;
      frame_wrap_q <= 1'b0;
    end else begin
      if (load) begin
        pend_val <= value;
        pend_dp  <= dp_in;
      end
      if (enable) begin
        cnt <= pre_wrap ? '0 : cnt + 1'b1;
      end
      if (pre_wrap) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
      // A load landing on the wrap edge bypasses the pending register.
      if (frame_wrap) begin
        disp_val <= load ? value : pend_val;
        disp_dp  <= load ? dp_in : pend_dp;
      end
      frame_wrap_q <= frame_wrap;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_out    <= SEG_BLANK;
      dp_out     <= 1'b1;
      digit_sel  <= '1;
      frame_done <= 1'b0;
    end else if (enable) begin
      seg_out    <= cur_blank ? SEG_BLANK : dec_seg;
      dp_out     <= ~cur_dp;
      digit_sel  <= cur_sel;
      frame_done <= frame_wrap_q;
    end else begin
      seg_out    <= SEG_BLANK;
      dp_out     <= 1'b1;
      digit_sel  <= '1;
      frame_done <= 1'b0;
    end
  end

endmodule
